// File: rtl/shrv_pkg.sv
// Shared definitions for the shrv fetch front end: datapath width,
// instruction size, the buffered fetch entry and the fetch state encoding.
package shrv_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  // One buffered instruction together with the byte address it came from.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_IDLE_RESET,
    FETCH_RUN
  } fetch_state_e;

  // Force a byte address onto an instruction boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory port, redirect input and the
// instruction hand-off to the consumer.
interface fetch_unit_if;
  import shrv_pkg::*;

  logic [XLEN-1:0] A;
  logic [XLEN-1:0] RD;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  // Fetch unit side.
  modport master (
    output A,
    input  RD,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  // Memory / consumer side.
  modport slave (
    input  A,
    output RD,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );

endinterface

// File: rtl/fetch_buf.sv
// Instruction buffer: synchronous FIFO of fetch entries with a flush that
// empties it in one cycle. The head entry is read straight out of storage,
// so the consumer sees registered data only.
module fetch_buf
  import shrv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A flush discards the write of the same cycle; popping an empty FIFO is ignored.
  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Entry storage.
  // NOTE: storage has no reset; count and pointers decide what is valid, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; flush wins over any push or pop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word addresses to a one-cycle-latency
// instruction memory, captures returning words into a small buffer and
// hands them to the consumer with a valid/ready handshake. A redirect
// flushes everything in flight and restarts fetch at the new target.
module fetch_unit
  import shrv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  fetch_unit_if.master   bus
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int OW = CW + 1;

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic            inflight_q;

  logic [CW-1:0]   buf_count;
  logic [OW-1:0]   occupancy;
  logic            pop;
  logic            push;
  logic            issue;
  fetch_entry_t    wentry;
  fetch_entry_t    head;

  // Space is reserved for the word already in flight, and a pop this cycle frees a slot.
  assign pop       = bus.inst_valid && bus.inst_ready;
  assign occupancy = OW'(buf_count) + OW'(inflight_q) - OW'(pop);
  assign issue     = !bus.redirect_valid && (occupancy < OW'(BUF_DEPTH));

  // The word returning this cycle belongs to the address issued last cycle.
  assign push   = inflight_q && !bus.redirect_valid;
  assign wentry = '{inst: bus.RD, pc: inflight_pc_q};

  // Fetch PC, in-flight tracking and state sequencing.
  // NOTE: non-blocking assignments here so every flop samples the pre-edge values of its peers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= FETCH_IDLE_RESET;
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
    end else begin
      case (state_q)
        FETCH_IDLE_RESET: state_q <= FETCH_RUN;
        default:          state_q <= FETCH_RUN;
      endcase
      if (bus.redirect_valid) begin
        pc_q       <= align_pc(bus.redirect_pc);
        inflight_q <= 1'b0;
      end else if (issue) begin
        pc_q          <= pc_q + XLEN'(INST_BYTES);
        inflight_pc_q <= pc_q;
        inflight_q    <= 1'b1;
      end else begin
        inflight_q <= 1'b0;
      end
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .CLK   (CLK),
    .RST_N (RST_N),
    .flush (bus.redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .count (buf_count)
  );

  assign bus.A          = pc_q;
  assign bus.inst_valid = (buf_count != '0);
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects
// (buffered, with transfer, wrap-around, back-to-back) and async reset.
module tb_fetch_unit;
  import shrv_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  fetch_unit_if bus ();
  fetch_unit_if bus3 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(3)) u_dut3 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus3)
  );

  always #5 CLK = ~CLK;

  // Instruction memory model: one-cycle latency, word = address ^ KEY.
  always @(posedge CLK) begin
    bus.RD  <= bus.A ^ KEY;
    bus3.RD <= bus3.A ^ KEY;
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic release_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Release reset with inst_ready=1, record every transfer for 'cycles' cycles,
  // pulsing redirects after the samples of cycles r1_at / r2_at (0 = none).
  task automatic collect(input int cycles, input int r1_at, input logic [31:0] r1_pc,
                         input int r2_at, input logic [31:0] r2_pc);
    got_pc.delete();
    got_inst.delete();
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    release_reset();
    for (int i = 1; i <= cycles; i++) begin
      @(negedge CLK);
      if (bus.inst_valid && bus.inst_ready) begin
        got_pc.push_back(bus.inst_pc);
        got_inst.push_back(bus.inst);
      end
      bus.redirect_valid = (i == r1_at) || (i == r2_at);
      bus.redirect_pc    = (i == r2_at) ? r2_pc : r1_pc;
    end
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (bus.A !== 32'h0) begin n_bad++; $display("FAIL reset_A: got %h want 00000000", bus.A); end
      n_cmp++;
      if (bus.inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid); end
      n_cmp++;
      if (u_dut.buf_count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", u_dut.buf_count); end
      n_cmp++;
      if (u_dut.inflight_q !== 1'b0) begin n_bad++; $display("FAIL reset_inflight: got %b want 0", u_dut.inflight_q); end
      n_cmp++;
      if (bus3.inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid3: got %b want 0", bus3.inst_valid); end
    end
  endtask

  task automatic test_stream();
    bus.inst_ready = 1'b1;
    release_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        n_cmp++;
        if (bus.inst_valid !== 1'b0 || bus.A !== 32'h4) begin
          n_bad++; $display("FAIL stream_first: got valid=%b A=%h want valid=0 A=00000004", bus.inst_valid, bus.A);
        end
      end else begin
        n_cmp++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * (k - 2)) || bus.inst !== word_at(32'(4 * (k - 2)))) begin
          n_bad++; $display("FAIL stream_k%0d: got valid=%b pc=%h inst=%h want pc=%h", k, bus.inst_valid, bus.inst_pc, bus.inst, 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  task automatic test_stall();
    bus.inst_ready = 1'b0;
    release_reset();
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (bus.A !== 32'h8 || u_dut.buf_count !== 2'd2) begin
        n_bad++; $display("FAIL stall_hold%0d: got A=%h count=%0d want A=00000008 count=2", i, bus.A, u_dut.buf_count);
      end
      n_cmp++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst !== word_at(32'h0)) begin
        n_bad++; $display("FAIL stall_head%0d: got valid=%b pc=%h inst=%h want pc=00000000", i, bus.inst_valid, bus.inst_pc, bus.inst);
      end
    end
    bus.inst_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge CLK);
      n_cmp++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * j) || bus.inst !== word_at(32'(4 * j))) begin
        n_bad++; $display("FAIL stall_resume%0d: got valid=%b pc=%h want pc=%h", j, bus.inst_valid, bus.inst_pc, 32'(4 * j));
      end
    end
  endtask

  task automatic test_redirect_buffered();
    logic [31:0] exp_pc[$];
    exp_pc = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    got_pc.delete();
    got_inst.delete();
    bus3.inst_ready = 1'b0;
    release_reset();
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (u_dut3.buf_count !== 2'd2 || u_dut3.inflight_q !== 1'b1) begin
      n_bad++; $display("FAIL rdbuf_setup: got count=%0d inflight=%b want count=2 inflight=1", u_dut3.buf_count, u_dut3.inflight_q);
    end
    bus3.redirect_pc    = 32'h103;
    bus3.redirect_valid = 1'b1;
    @(negedge CLK);
    bus3.redirect_valid = 1'b0;
    n_cmp++;
    if (bus3.inst_valid !== 1'b0 || bus3.A !== 32'h100) begin
      n_bad++; $display("FAIL rdbuf_flush: got valid=%b A=%h want valid=0 A=00000100", bus3.inst_valid, bus3.A);
    end
    bus3.inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (bus3.inst_valid && bus3.inst_ready) begin
        got_pc.push_back(bus3.inst_pc);
        got_inst.push_back(bus3.inst);
      end
    end
    bus3.inst_ready = 1'b0;
    n_cmp++;
    if (got_pc.size() != exp_pc.size()) begin
      n_bad++; $display("FAIL rdbuf_len: got %0d transfers want %0d", got_pc.size(), exp_pc.size());
    end
    for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc[i] || got_inst[i] !== word_at(exp_pc[i])) begin
        n_bad++; $display("FAIL rdbuf_seq%0d: got pc=%h inst=%h want pc=%h", i, got_pc[i], got_inst[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_redirect_transfer();
    logic [31:0] exp_pc[$];
    exp_pc = '{32'h0, 32'h4, 32'h200, 32'h204, 32'h208};
    collect(8, 3, 32'h201, 0, 32'h0);
    n_cmp++;
    if (got_pc.size() != exp_pc.size()) begin
      n_bad++; $display("FAIL rdxfer_len: got %0d transfers want %0d", got_pc.size(), exp_pc.size());
    end
    for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc[i] || got_inst[i] !== word_at(exp_pc[i])) begin
        n_bad++; $display("FAIL rdxfer_seq%0d: got pc=%h inst=%h want pc=%h", i, got_pc[i], got_inst[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc[$];
    exp_pc = '{32'h0, 32'h4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    collect(9, 3, 32'hFFFF_FFF8, 0, 32'h0);
    n_cmp++;
    if (got_pc.size() != exp_pc.size()) begin
      n_bad++; $display("FAIL wrap_len: got %0d transfers want %0d", got_pc.size(), exp_pc.size());
    end
    for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc[i] || got_inst[i] !== word_at(exp_pc[i])) begin
        n_bad++; $display("FAIL wrap_seq%0d: got pc=%h inst=%h want pc=%h", i, got_pc[i], got_inst[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc[$];
    exp_pc = '{32'h0, 32'h4, 32'h400, 32'h404, 32'h408};
    collect(9, 3, 32'h300, 4, 32'h400);
    n_cmp++;
    if (got_pc.size() != exp_pc.size()) begin
      n_bad++; $display("FAIL b2b_len: got %0d transfers want %0d", got_pc.size(), exp_pc.size());
    end
    for (int i = 0; i < exp_pc.size() && i < got_pc.size(); i++) begin
      n_cmp++;
      if (got_pc[i] !== exp_pc[i] || got_inst[i] !== word_at(exp_pc[i])) begin
        n_bad++; $display("FAIL b2b_seq%0d: got pc=%h inst=%h want pc=%h", i, got_pc[i], got_inst[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bus.inst_ready = 1'b1;
    release_reset();
    repeat (4) @(negedge CLK);
    n_cmp++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h8) begin
      n_bad++; $display("FAIL midrst_pre: got valid=%b pc=%h want valid=1 pc=00000008", bus.inst_valid, bus.inst_pc);
    end
    #2 RST_N = 1'b0;
    #1;
    n_cmp++;
    if (bus.inst_valid !== 1'b0 || bus.A !== 32'h0) begin
      n_bad++; $display("FAIL midrst_async: got valid=%b A=%h want valid=0 A=00000000", bus.inst_valid, bus.A);
    end
    n_cmp++;
    if (u_dut.buf_count !== 2'd0 || u_dut.inflight_q !== 1'b0) begin
      n_bad++; $display("FAIL midrst_state: got count=%0d inflight=%b want 0/0", u_dut.buf_count, u_dut.inflight_q);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        n_cmp++;
        if (bus.inst_valid !== 1'b0 || bus.A !== 32'h4) begin
          n_bad++; $display("FAIL midrst_first: got valid=%b A=%h want valid=0 A=00000004", bus.inst_valid, bus.A);
        end
      end else begin
        n_cmp++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * (k - 2)) || bus.inst !== word_at(32'(4 * (k - 2)))) begin
          n_bad++; $display("FAIL midrst_k%0d: got valid=%b pc=%h want pc=%h", k, bus.inst_valid, bus.inst_pc, 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  initial begin
    RST_N               = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.inst_ready      = 1'b0;
    bus3.redirect_valid = 1'b0;
    bus3.redirect_pc    = 32'h0;
    bus3.inst_ready     = 1'b0;

    test_reset();
    test_stream();
    test_stall();
    test_redirect_buffered();
    test_redirect_transfer();
    test_wrap();
    test_back_to_back();
    test_reset_midstream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
